// File: rtl/vending_pkg.sv
// Shared types and coin decoding for the vending controllers.
// Coin codes map to 5-unit credit steps; 25 can be disabled per instance.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    function automatic logic [2:0] coin_units(input logic [1:0] code, input logic en25);
        logic [2:0] units;
        case (code)
            COIN_5:  units = 3'd1;
            COIN_10: units = 3'd2;
            COIN_25: units = en25 ? 3'd5 : 3'd0;
            default: units = 3'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vending_mealy_param.sv
// Parametrised coin vending FSM: Mealy dispense, change paid as contiguous chg5 pulses.
// Zero-latency vend/first change pulse; coins are rejected (not stalled) while paying out.
module vending_mealy_param
    import vending_pkg::*;
#(
    parameter int unsigned PRICE_UNITS = 4,
    parameter bit          COIN25_EN   = 1'b1,
    localparam int unsigned CW         = $clog2(PRICE_UNITS + 5) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          cancel,
    output logic          dispense,
    output logic          chg5,
    output logic          coin_reject,
    output logic          busy,
    output logic [CW-1:0] credit
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE_UNITS);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] chg_q, chg_d;

    logic [CW-1:0] coin_v;
    logic [CW-1:0] sum;
    logic [CW-1:0] change;
    logic          coin_present;
    logic          dispense_c, chg5_c, reject_c;

    assign coin_v       = CW'(coin_units(coin, COIN25_EN));
    assign sum          = credit_q + coin_v;
    assign change       = sum - PRICE_C;
    assign coin_present = (coin != COIN_NONE);

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        chg_d      = chg_q;
        dispense_c = 1'b0;
        chg5_c     = 1'b0;
        reject_c   = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                if (cancel) begin
                    // Cancel wins over any coin presented in the same cycle.
                    reject_c = coin_present;
                    if (credit_q != '0) begin
                        chg5_c   = 1'b1;
                        chg_d    = credit_q - ONE_C;
                        credit_d = '0;
                        state_d  = (credit_q > ONE_C) ? CHANGE : IDLE;
                    end
                end else if (coin_present && coin_v == '0) begin
                    reject_c = 1'b1;
                end else if (coin_v != '0) begin
                    if (sum < PRICE_C) begin
                        credit_d = sum;
                        state_d  = ACCUM;
                    end else begin
                        dispense_c = 1'b1;
                        credit_d   = '0;
                        state_d    = IDLE;
                        if (change != '0) begin
                            chg5_c = 1'b1;
                            chg_d  = change - ONE_C;
                            if (change > ONE_C) begin
                                state_d = CHANGE;
                            end
                        end
                    end
                end
            end
            CHANGE: begin
                chg5_c   = 1'b1;
                reject_c = coin_present;
                chg_d    = chg_q - ONE_C;
                if (chg_q == ONE_C) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                chg_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            chg_q    <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            chg_q    <= chg_d;
        end
    end

    // Mealy outputs are gated so they drop the instant reset asserts.
    assign dispense    = dispense_c & rst;
    assign chg5        = chg5_c & rst;
    assign coin_reject = reject_c & rst;
    assign busy        = (state_q == CHANGE);
    assign credit      = credit_q;

endmodule

// File: tb/tb_vending_mealy_param.sv
module tb_vending_mealy_param;

    logic       clk;
    logic       rst;
    logic [1:0] coin;
    logic       cancel;

    logic       a_disp, a_chg, a_rej, a_busy;
    logic [4:0] a_credit;
    logic       b_disp, b_chg, b_rej, b_busy;
    logic [4:0] b_credit;

    logic       ma_d, ma_c, ma_r, mb_d, mb_c, mb_r;
    logic       ra_busy, rb_busy;
    logic [4:0] ra_credit, rb_credit;

    int errors = 0;
    int checks = 0;

    vending_mealy_param #(.PRICE_UNITS(4), .COIN25_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
        .dispense(a_disp), .chg5(a_chg), .coin_reject(a_rej),
        .busy(a_busy), .credit(a_credit)
    );

    vending_mealy_param #(.PRICE_UNITS(4), .COIN25_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
        .dispense(b_disp), .chg5(b_chg), .coin_reject(b_rej),
        .busy(b_busy), .credit(b_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus: Mealy outputs captured mid-low phase, registers after the edge.
    task automatic cyc(input logic [1:0] c, input logic can);
        @(negedge clk);
        coin = c;
        cancel = can;
        #2;
        ma_d = a_disp; ma_c = a_chg; ma_r = a_rej;
        mb_d = b_disp; mb_c = b_chg; mb_r = b_rej;
        @(posedge clk);
        #1;
        ra_busy = a_busy; ra_credit = a_credit;
        rb_busy = b_busy; rb_credit = b_credit;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        coin = 2'b00;
        cancel = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        coin = 2'b01;
        cancel = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({a_disp, a_chg, a_rej, a_busy} !== 4'b0000 || a_credit !== 5'd0) begin
            errors++;
            $display("FAIL reset_a: disp/chg/rej/busy=%b credit=%0d want 0000/0",
                     {a_disp, a_chg, a_rej, a_busy}, a_credit);
        end
        checks++;
        if ({b_disp, b_chg, b_rej, b_busy} !== 4'b0000 || b_credit !== 5'd0) begin
            errors++;
            $display("FAIL reset_b: disp/chg/rej/busy=%b credit=%0d want 0000/0",
                     {b_disp, b_chg, b_rej, b_busy}, b_credit);
        end
        coin = 2'b00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_exact_price();
        apply_reset();
        cyc(2'b01, 1'b0);
        checks++;
        if (ma_d !== 1'b0 || ra_credit !== 5'd1) begin
            errors++;
            $display("FAIL exact_c1: disp=%b credit=%0d want 0/1", ma_d, ra_credit);
        end
        cyc(2'b00, 1'b0);
        cyc(2'b01, 1'b0);
        checks++;
        if (ra_credit !== 5'd2) begin
            errors++;
            $display("FAIL exact_c2: credit=%0d want 2", ra_credit);
        end
        cyc(2'b00, 1'b0);
        cyc(2'b10, 1'b0);
        checks++;
        if (ma_d !== 1'b1 || ma_c !== 1'b0 || ma_r !== 1'b0) begin
            errors++;
            $display("FAIL exact_vend: disp/chg/rej=%b%b%b want 100", ma_d, ma_c, ma_r);
        end
        checks++;
        if (ra_credit !== 5'd0 || ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL exact_after: credit=%0d busy=%b want 0/0", ra_credit, ra_busy);
        end
    endtask

    task automatic test_one_change();
        apply_reset();
        cyc(2'b10, 1'b0);
        checks++;
        if (ra_credit !== 5'd2) begin
            errors++;
            $display("FAIL one_chg_c2: credit=%0d want 2", ra_credit);
        end
        cyc(2'b01, 1'b0);
        checks++;
        if (ra_credit !== 5'd3 || ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL one_chg_c3: credit=%0d busy=%b want 3/0", ra_credit, ra_busy);
        end
        cyc(2'b10, 1'b0);
        checks++;
        if (ma_d !== 1'b1 || ma_c !== 1'b1) begin
            errors++;
            $display("FAIL one_chg_vend: disp/chg=%b%b want 11", ma_d, ma_c);
        end
        checks++;
        if (ra_busy !== 1'b0 || ra_credit !== 5'd0) begin
            errors++;
            $display("FAIL one_chg_after: busy=%b credit=%0d want 0/0", ra_busy, ra_credit);
        end
        cyc(2'b00, 1'b0);
        checks++;
        if (ma_c !== 1'b0 || ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL one_chg_tail: chg=%b busy=%b want 0/0", ma_c, ra_busy);
        end
    endtask

    task automatic test_change_train();
        int pulses;
        apply_reset();
        pulses = 0;
        cyc(2'b10, 1'b0);
        cyc(2'b11, 1'b0);
        pulses += int'(ma_c);
        checks++;
        if (ma_d !== 1'b1 || ma_c !== 1'b1 || ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL train_vend: disp/chg/busy=%b%b%b want 111", ma_d, ma_c, ra_busy);
        end
        cyc(2'b00, 1'b1);
        pulses += int'(ma_c);
        checks++;
        if (ma_c !== 1'b1 || ma_d !== 1'b0 || ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL train_busy1: chg/disp/busy=%b%b%b want 101", ma_c, ma_d, ra_busy);
        end
        cyc(2'b01, 1'b0);
        pulses += int'(ma_c);
        checks++;
        if (ma_c !== 1'b1 || ma_r !== 1'b1 || ra_credit !== 5'd0) begin
            errors++;
            $display("FAIL train_reject: chg/rej=%b%b credit=%0d want 11/0", ma_c, ma_r, ra_credit);
        end
        checks++;
        if (ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL train_exit: busy=%b want 0", ra_busy);
        end
        cyc(2'b00, 1'b0);
        pulses += int'(ma_c);
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL train_count: pulses=%0d want 3", pulses);
        end
    endtask

    task automatic test_cancel();
        apply_reset();
        cyc(2'b00, 1'b1);
        checks++;
        if (ma_c !== 1'b0 || ma_r !== 1'b0 || ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_noop: chg/rej/busy=%b%b%b want 000", ma_c, ma_r, ra_busy);
        end
        cyc(2'b01, 1'b0);
        cyc(2'b10, 1'b0);
        checks++;
        if (ra_credit !== 5'd3) begin
            errors++;
            $display("FAIL cancel_credit: credit=%0d want 3", ra_credit);
        end
        cyc(2'b10, 1'b1);
        checks++;
        if (ma_r !== 1'b1 || ma_d !== 1'b0 || ma_c !== 1'b1) begin
            errors++;
            $display("FAIL cancel_trig: rej/disp/chg=%b%b%b want 101", ma_r, ma_d, ma_c);
        end
        checks++;
        if (ra_credit !== 5'd0 || ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_after: credit=%0d busy=%b want 0/1", ra_credit, ra_busy);
        end
        cyc(2'b00, 1'b0);
        checks++;
        if (ma_c !== 1'b1 || ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_p2: chg=%b busy=%b want 1/1", ma_c, ra_busy);
        end
        cyc(2'b00, 1'b0);
        checks++;
        if (ma_c !== 1'b1 || ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_p3: chg=%b busy=%b want 1/0", ma_c, ra_busy);
        end
        cyc(2'b00, 1'b0);
        checks++;
        if (ma_c !== 1'b0) begin
            errors++;
            $display("FAIL cancel_tail: chg=%b want 0", ma_c);
        end
    endtask

    task automatic test_coin25_disabled();
        apply_reset();
        cyc(2'b01, 1'b0);
        checks++;
        if (rb_credit !== 5'd1) begin
            errors++;
            $display("FAIL no25_c1: credit=%0d want 1", rb_credit);
        end
        cyc(2'b11, 1'b0);
        checks++;
        if (mb_r !== 1'b1 || mb_d !== 1'b0 || mb_c !== 1'b0) begin
            errors++;
            $display("FAIL no25_reject: rej/disp/chg=%b%b%b want 100", mb_r, mb_d, mb_c);
        end
        checks++;
        if (rb_credit !== 5'd1 || rb_busy !== 1'b0) begin
            errors++;
            $display("FAIL no25_hold: credit=%0d busy=%b want 1/0", rb_credit, rb_busy);
        end
        cyc(2'b00, 1'b1);
        checks++;
        if (mb_c !== 1'b1 || rb_credit !== 5'd0 || rb_busy !== 1'b0) begin
            errors++;
            $display("FAIL no25_refund: chg=%b credit=%0d busy=%b want 1/0/0", mb_c, rb_credit, rb_busy);
        end
        cyc(2'b00, 1'b0);
        checks++;
        if (mb_c !== 1'b0) begin
            errors++;
            $display("FAIL no25_tail: chg=%b want 0", mb_c);
        end
    endtask

    task automatic test_reset_mid_change();
        apply_reset();
        cyc(2'b10, 1'b0);
        cyc(2'b11, 1'b0);
        checks++;
        if (ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: busy=%b want 1", ra_busy);
        end
        @(negedge clk);
        coin = 2'b00;
        cancel = 1'b0;
        #2;
        checks++;
        if (a_chg !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: chg=%b want 1", a_chg);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_chg !== 1'b0 || a_busy !== 1'b0 || a_credit !== 5'd0) begin
            errors++;
            $display("FAIL midrst_async: chg=%b busy=%b credit=%0d want 0/0/0", a_chg, a_busy, a_credit);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc(2'b01, 1'b0);
        checks++;
        if (ma_c !== 1'b0 || ra_credit !== 5'd1 || ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_resume: chg=%b credit=%0d busy=%b want 0/1/0", ma_c, ra_credit, ra_busy);
        end
        cyc(2'b00, 1'b0);
        checks++;
        if (ma_c !== 1'b0) begin
            errors++;
            $display("FAIL midrst_tail: chg=%b want 0", ma_c);
        end
    endtask

    initial begin
        rst = 1'b1;
        coin = 2'b00;
        cancel = 1'b0;
        test_reset();
        test_exact_price();
        test_one_change();
        test_change_train();
        test_cancel();
        test_coin25_disabled();
        test_reset_mid_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
